// File: rtl/neuron_mac_engine.sv
// neuron_mac_engine: serial MAC engine computing one layer from the activation RAM and weight store.
// Define NMAC_RELU_EN to apply ReLU after saturation; otherwise the layer is linear.
module neuron_mac_engine #(
    parameter int DATA_W      = 16,
    parameter int FRAC_W      = 8,
    parameter int ACC_W       = 40,
    parameter int MAX_NEURONS = 32,
    parameter int MAX_DEPTH   = 8,
    parameter int NEUR_W      = 6,
    parameter int LAYER_W     = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [LAYER_W-1:0]            i_src_layer,
    input  logic [NEUR_W-1:0]             i_num_inputs,
    input  logic [NEUR_W-1:0]             i_num_outputs,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic                          o_ram_rw,
    output logic [LAYER_W-1:0]            o_ram_layer_index,
    output logic [NEUR_W-1:0]             o_ram_neuron_index,
    output logic [DATA_W-1:0]             o_ram_d_in,
    input  logic [MAX_NEURONS*DATA_W-1:0] i_ram_d_out,
    output logic [LAYER_W-1:0]            o_w_layer,
    output logic [NEUR_W-1:0]             o_w_neuron,
    output logic [NEUR_W-1:0]             o_w_input,
    input  logic signed [DATA_W-1:0]      i_w_data
);
    localparam int IDX_W = $clog2(MAX_NEURONS);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(DATA_W-1)-1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_MAC, S_DRAIN, S_ACT, S_WRITE, S_DONE} state_t;
    state_t r_state, w_next;

    logic [LAYER_W-1:0]        r_src;
    logic [NEUR_W-1:0]         r_ni, r_no, r_i, r_pi, r_j;
    logic                      r_pv, r_err;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]         r_res;
    logic signed [DATA_W-1:0]  r_act [MAX_NEURONS];

    logic                      w_bad;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_term, w_shift;
    logic signed [DATA_W-1:0]  w_sat, w_act;

    assign w_bad = (i_src_layer == '0) || (i_src_layer >= LAYER_W'(MAX_DEPTH-1)) ||
                   (i_num_inputs == '0) || (i_num_inputs > NEUR_W'(MAX_NEURONS-1)) ||
                   (i_num_outputs == '0) || (i_num_outputs > NEUR_W'(MAX_NEURONS-1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? (w_bad ? S_DONE : S_FETCH) : S_IDLE;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_MAC;
            S_MAC:   w_next = (r_i == r_ni) ? S_DRAIN : S_MAC;
            S_DRAIN: w_next = S_ACT;
            S_ACT:   w_next = S_WRITE;
            S_WRITE: w_next = (r_j == r_no - NEUR_W'(1)) ? S_DONE : S_MAC;
            default: w_next = S_IDLE;
        endcase
    end

    // Data for the address issued last cycle: index r_pi == num_inputs selects the bias.
    always_comb begin
        w_prod  = r_act[r_pi[IDX_W-1:0]] * i_w_data;
        w_term  = (r_pi == r_ni)
                ? {{(ACC_W-DATA_W-FRAC_W){i_w_data[DATA_W-1]}}, i_w_data, {FRAC_W{1'b0}}}
                : {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
        w_shift = r_acc >>> FRAC_W;
        w_sat   = (w_shift > SAT_HI) ? {1'b0, {(DATA_W-1){1'b1}}}
                : (w_shift < SAT_LO) ? {1'b1, {(DATA_W-1){1'b0}}}
                : w_shift[DATA_W-1:0];
`ifdef NMAC_RELU_EN
        w_act   = w_sat[DATA_W-1] ? '0 : w_sat;
`else
        w_act   = w_sat;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src <= '0;
            r_ni  <= '0;
            r_no  <= '0;
            r_i   <= '0;
            r_pi  <= '0;
            r_j   <= '0;
            r_pv  <= 1'b0;
            r_err <= 1'b0;
            r_acc <= '0;
            r_res <= '0;
            for (int k = 0; k < MAX_NEURONS; k++) r_act[k] <= '0;
        end else begin
            r_pv <= (r_state == S_MAC);
            r_pi <= r_i;
            if (r_state == S_IDLE && i_start) begin
                r_err <= w_bad;
                r_src <= i_src_layer;
                r_ni  <= i_num_inputs;
                r_no  <= i_num_outputs;
            end
            if (r_state == S_LOAD) begin
                for (int k = 0; k < MAX_NEURONS; k++) r_act[k] <= i_ram_d_out[k*DATA_W +: DATA_W];
                r_i <= '0;
                r_j <= '0;
            end
            if (r_state == S_MAC) r_i <= r_i + NEUR_W'(1);
            if (r_pv) r_acc <= r_acc + w_term;
            if (r_state == S_ACT) r_res <= w_act;
            if (r_state == S_WRITE) begin
                r_acc <= '0;
                r_i   <= '0;
                r_j   <= r_j + NEUR_W'(1);
            end
            if (r_state == S_LOAD) r_acc <= '0;
        end
    end

    always_comb begin
        o_busy             = (r_state != S_IDLE) && (r_state != S_DONE);
        o_done             = (r_state == S_DONE);
        o_err              = r_err;
        o_ram_rw           = (r_state == S_WRITE);
        o_ram_layer_index  = (r_state == S_FETCH) ? r_src
                           : (r_state == S_WRITE) ? r_src + LAYER_W'(1) : '0;
        o_ram_neuron_index = (r_state == S_WRITE) ? r_j : '0;
        o_ram_d_in         = (r_state == S_WRITE) ? r_res : '0;
        o_w_layer          = r_src;
        o_w_neuron         = r_j;
        o_w_input          = r_i;
    end
endmodule
